// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared types and constants for the hash request front end
//   op_e    : table operation encodings carried on req_op_i / op_o / resp_op_o
//   state_e : request sequencer FSM states
//   ST_*    : bit positions inside the 4-bit controller status word
package hash_pkg;

  typedef enum logic [1:0] {
    OP_NOTHING = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_DELETE  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam int ST_KEY_ALREADY_PRESENT = 0;
  localparam int ST_NO_ELEMENT_FOUND    = 1;
  localparam int ST_NO_WRITE_SPACE      = 2;
  localparam int ST_NO_DELETION_TARGET  = 3;

endpackage

// File: rtl/hash_unit.sv
// rtl/hash_unit.sv - combinational per-table cuckoo hash
//   key_i : key to hash
//   adr_o : NUMBER_OF_TABLES addresses packed LSB-first, table t at [t*HS +: HS]
// Table t hashes fold(key ^ (key >> (t+1))); fold zero-extends to a whole
// number of HS-bit chunks and XORs the chunks together.
module hash_unit #(
  parameter int KEY_WIDTH           = 8,
  parameter int HASH_TABLE_MAX_SIZE = 4,
  parameter int NUMBER_OF_TABLES    = 3
) (
  input  logic [KEY_WIDTH-1:0]                            key_i,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] adr_o
);

  localparam int HS     = HASH_TABLE_MAX_SIZE;
  localparam int CHUNKS = (KEY_WIDTH + HS - 1) / HS;
  localparam int PW     = CHUNKS * HS;

  for (genvar t = 0; t < NUMBER_OF_TABLES; t++) begin : g_tbl
    logic [PW-1:0] mixed;
    logic [HS-1:0] h;

    assign mixed = PW'(key_i ^ (key_i >> (t + 1)));

    always_comb begin
      h = '0;
      for (int c = 0; c < CHUNKS; c++) begin
        h = h ^ mixed[c*HS +: HS];
      end
    end

    assign adr_o[t*HS +: HS] = h;
  end

endmodule

// File: rtl/hash_request_sequencer.sv
// rtl/hash_request_sequencer.sv - one-at-a-time front end for the hash-table controller
//   req_*            : request handshake (op, key, write payload)
//   rd_en_o          : table read strobe, hash_adr_o : per-table addresses
//   key_o/data_o/op_o: controller operation inputs, op_o non-zero only in EXEC
//   ctrl_*_i         : controller result and status flags
//   resp_*           : held response, released by resp_ready_i
module hash_request_sequencer
  import hash_pkg::*;
#(
  parameter int KEY_WIDTH           = 8,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 4,
  parameter int READ_LATENCY        = 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            req_valid_i,
  output logic                                            req_ready_o,
  input  logic [1:0]                                      req_op_i,
  input  logic [KEY_WIDTH-1:0]                            req_key_i,
  input  logic [DATA_WIDTH-1:0]                           req_data_i,
  output logic                                            rd_en_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0] hash_adr_o,
  output logic [KEY_WIDTH-1:0]                            key_o,
  output logic [DATA_WIDTH-1:0]                           data_o,
  output logic [1:0]                                      op_o,
  input  logic [DATA_WIDTH-1:0]                           ctrl_read_data_i,
  input  logic [3:0]                                      ctrl_status_i,
  output logic                                            resp_valid_o,
  input  logic                                            resp_ready_i,
  output logic [1:0]                                      resp_op_o,
  output logic [DATA_WIDTH-1:0]                           resp_data_o,
  output logic [3:0]                                      resp_status_o
);

  localparam int ADR_W = HASH_TABLE_MAX_SIZE * NUMBER_OF_TABLES;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              op_q;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [ADR_W-1:0]        adr_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;
  logic [3:0]              resp_status_q;
  logic [ADR_W-1:0]        hash_adr;
  logic                    accept;

  hash_unit #(
    .KEY_WIDTH          (KEY_WIDTH),
    .HASH_TABLE_MAX_SIZE(HASH_TABLE_MAX_SIZE),
    .NUMBER_OF_TABLES   (NUMBER_OF_TABLES)
  ) u_hash (
    .key_i(req_key_i),
    .adr_o(hash_adr)
  );

  assign accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (accept && req_op_i != OP_NOTHING) state_d = S_READ;
      S_READ: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(READ_LATENCY - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_EXEC;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // op_o is decoded straight from state so an async reset clears it at once.
  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    rd_en_o      = (state_q == S_READ);
    op_o         = (state_q == S_EXEC) ? op_q : OP_NOTHING;
    resp_valid_o = (state_q == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      key_q         <= '0;
      data_q        <= '0;
      adr_q         <= '0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= req_op_i;
        key_q  <= req_key_i;
        data_q <= req_data_i;
        // Addresses only move for real operations so the tables see a stable value.
        if (req_op_i != OP_NOTHING) adr_q <= hash_adr;
      end
      if (state_q == S_EXEC) begin
        resp_status_q <= ctrl_status_i;
        resp_data_q   <= (op_q == OP_READ && !ctrl_status_i[ST_NO_ELEMENT_FOUND])
                         ? ctrl_read_data_i : '0;
      end
    end
  end

  assign hash_adr_o    = adr_q;
  assign key_o         = key_q;
  assign data_o        = data_q;
  assign resp_op_o     = op_q;
  assign resp_data_o   = resp_data_q;
  assign resp_status_o = resp_status_q;

endmodule

// File: tb/tb_hash_request_sequencer.sv
// tb/tb_hash_request_sequencer.sv - directed self-checking bench, READ_LATENCY 1 and 3
module tb_hash_request_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [7:0]  req_key;
  logic [31:0] req_data;
  logic [31:0] ctrl_rdata;
  logic [3:0]  ctrl_status;
  logic        resp_ready;

  logic        req_ready_a, rd_en_a, resp_valid_a;
  logic [11:0] adr_a;
  logic [7:0]  key_a;
  logic [31:0] data_a, resp_data_a;
  logic [1:0]  op_a, resp_op_a;
  logic [3:0]  resp_status_a;

  logic        req_ready_b, rd_en_b, resp_valid_b;
  logic [11:0] adr_b;
  logic [7:0]  key_b;
  logic [31:0] data_b, resp_data_b;
  logic [1:0]  op_b, resp_op_b;
  logic [3:0]  resp_status_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hash_request_sequencer #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_a),
    .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
    .rd_en_o(rd_en_a), .hash_adr_o(adr_a), .key_o(key_a), .data_o(data_a), .op_o(op_a),
    .ctrl_read_data_i(ctrl_rdata), .ctrl_status_i(ctrl_status),
    .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready),
    .resp_op_o(resp_op_a), .resp_data_o(resp_data_a), .resp_status_o(resp_status_a)
  );

  hash_request_sequencer #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_b),
    .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
    .rd_en_o(rd_en_b), .hash_adr_o(adr_b), .key_o(key_b), .data_o(data_b), .op_o(op_b),
    .ctrl_read_data_i(ctrl_rdata), .ctrl_status_i(ctrl_status),
    .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready),
    .resp_op_o(resp_op_b), .resp_data_o(resp_data_b), .resp_status_o(resp_status_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a_req_ready"}, req_ready_a, 1'b1);
    check({tag, "_a_resp_valid"}, resp_valid_a, 1'b0);
    check({tag, "_a_op"}, op_a, 2'b00);
    check({tag, "_a_rd_en"}, rd_en_a, 1'b0);
    check({tag, "_b_req_ready"}, req_ready_b, 1'b1);
    check({tag, "_b_op"}, op_b, 2'b00);
  endtask

  // Issues one request at cycle 0 and checks both latencies cycle by cycle.
  // Instance a (latency 1): rd_en 1, EXEC 3, resp 4. Instance b (latency 3): rd_en 1, EXEC 5, resp 6.
  task automatic run_op(input logic [1:0] op, input logic [7:0] key, input logic [31:0] data,
                        input logic [11:0] adr_exp, input logic [31:0] rdata_exp,
                        input logic [3:0] st_exp);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_data  = data;
    tick();
    req_valid = 1'b0;
    req_op    = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      check("a_rd_en", rd_en_a, c == 1);
      check("a_op", op_a, (c == 3) ? op : 2'b00);
      check("a_resp_valid", resp_valid_a, c == 4);
      check("b_rd_en", rd_en_b, c == 1);
      check("b_op", op_b, (c == 5) ? op : 2'b00);
      check("b_resp_valid", resp_valid_b, c == 6);
      if (c >= 1 && c <= 3) check("a_hash_adr", adr_a, adr_exp);
      if (c == 1) check("b_hash_adr", adr_b, adr_exp);
      if (c == 3) begin
        check("a_key_o", key_a, key);
        check("a_data_o", data_a, data);
      end
      if (c == 4) begin
        check("a_resp_op", resp_op_a, op);
        check("a_resp_data", resp_data_a, rdata_exp);
        check("a_resp_status", resp_status_a, st_exp);
        check("a_req_ready_resp", req_ready_a, 1'b0);
      end
      if (c == 6) begin
        check("b_resp_data", resp_data_b, rdata_exp);
        check("b_resp_status", resp_status_b, st_exp);
      end
      tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_op      = 2'b00;
    req_key     = 8'h00;
    req_data    = 32'h0;
    ctrl_rdata  = 32'h0;
    ctrl_status = 4'b0000;
    resp_ready  = 1'b1;

    repeat (2) tick();
    check_idle("reset");
    check("reset_a_adr", adr_a, 12'h000);
    check("reset_a_resp_status", resp_status_a, 4'h0);
    rst_n = 1'b1;
    tick();

    // Write key 5A: h0=0, h1=8, h2=4. Non-read op forces resp_data to 0.
    ctrl_rdata  = 32'hDEAD_BEEF;
    ctrl_status = 4'b0001;
    run_op(2'b10, 8'h5A, 32'h0000_1234, 12'h480, 32'h0, 4'b0001);

    // Read hit, key FF: h0=8, h1=C, h2=E.
    ctrl_rdata  = 32'h0000_1234;
    ctrl_status = 4'b0000;
    run_op(2'b01, 8'hFF, 32'h0, 12'hEC8, 32'h0000_1234, 4'b0000);

    // Read miss, key 00.
    ctrl_status = 4'b0010;
    run_op(2'b01, 8'h00, 32'h0, 12'h000, 32'h0, 4'b0010);

    // Delete with no target, key 5A.
    ctrl_status = 4'b1000;
    run_op(2'b11, 8'h5A, 32'h0, 12'h480, 32'h0, 4'b1000);

    // Backpressure: hold response for 6 cycles, ignored request pulse in between.
    ctrl_rdata  = 32'hCAFE_0001;
    ctrl_status = 4'b0000;
    resp_ready  = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_key = 8'hFF; req_data = 32'h0;
    tick();
    req_valid = 1'b0; req_op = 2'b00;
    repeat (3) tick();
    for (int c = 0; c < 6; c++) begin
      check("bp_resp_valid", resp_valid_a, 1'b1);
      check("bp_resp_data", resp_data_a, 32'hCAFE_0001);
      check("bp_resp_op", resp_op_a, 2'b01);
      check("bp_req_ready", req_ready_a, 1'b0);
      check("bp_rd_en", rd_en_a, 1'b0);
      if (c == 2) begin
        req_valid = 1'b1; req_op = 2'b10; req_key = 8'h11;
      end else begin
        req_valid = 1'b0; req_op = 2'b00;
      end
      tick();
    end
    req_valid = 1'b0; req_op = 2'b00;
    check("bp_b_resp_valid", resp_valid_b, 1'b1);
    resp_ready = 1'b1;
    #1;
    check("bp_still_valid", resp_valid_a, 1'b1);
    tick();
    check("bp_released_valid", resp_valid_a, 1'b0);
    check("bp_released_ready", req_ready_a, 1'b1);
    tick();
    check_idle("bp_after");

    // op 00 is accepted and dropped.
    req_valid = 1'b1; req_op = 2'b00; req_key = 8'h33;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("nop_rd_en", rd_en_a, 1'b0);
      check("nop_resp_valid", resp_valid_a, 1'b0);
      check("nop_req_ready", req_ready_a, 1'b1);
      check("nop_b_rd_en", rd_en_b, 1'b0);
    end
    req_valid = 1'b0;
    tick();

    // Reset while instance a is in WAIT.
    ctrl_status = 4'b0000;
    req_valid = 1'b1; req_op = 2'b10; req_key = 8'h5A; req_data = 32'h55;
    tick();
    req_valid = 1'b0; req_op = 2'b00;
    check("rw_rd_en", rd_en_a, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check_idle("rw_reset");
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rw_hold_a_op", op_a, 2'b00);
      check("rw_hold_b_op", op_b, 2'b00);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rw_no_stale_a", resp_valid_a, 1'b0);
      check("rw_no_stale_b", resp_valid_b, 1'b0);
      check("rw_no_op_a", op_a, 2'b00);
    end
    ctrl_rdata  = 32'h0BAD_F00D;
    ctrl_status = 4'b0000;
    run_op(2'b01, 8'h5A, 32'h0, 12'h480, 32'h0BAD_F00D, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
